// File: rtl/conv_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_arb_pkg
// Purpose  : Shared encodings and defaults for the conv engine SRAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
package conv_mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HOST   = 3'd3,
        ST_FINISH = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CV   = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam int DEF_HOST_MAX_WAIT = 8;
    localparam int DEF_DRAIN_CYCLES  = 4;
    localparam int DEF_HOST_BURST    = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mem_arb_port_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_port_mux
// Purpose  : Priority select onto the SRAM port plus read-owner tag steering.
// Revision : 1.0  initial release
// ============================================================================
module arb_port_mux
    import conv_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_allow,
    input  logic              cv_rd,
    input  logic [ADDR_W-1:0] cv_rd_addr,
    input  logic              cv_wr,
    input  logic [ADDR_W-1:0] cv_wr_addr,
    input  logic [DATA_W-1:0] cv_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              collide,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cv_rdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);

    owner_t r_tag;
    owner_t w_tag_next;
    logic   w_gnt;

    // Reset forces the port idle at once, even if conv strobes are still high.
    always_comb begin
        w_gnt     = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (cv_wr) begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cv_wr_addr;
                mem_wdata = cv_wdata;
            end else if (cv_rd) begin
                mem_ce   = 1'b1;
                mem_addr = cv_rd_addr;
            end else if (host_req && host_allow) begin
                w_gnt     = 1'b1;
                mem_ce    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
        end
    end

    always_comb begin
        w_tag_next = OWN_NONE;
        if (!reset && !cv_wr) begin
            if (cv_rd)
                w_tag_next = OWN_CV;
            else if (w_gnt && !host_we)
                w_tag_next = OWN_HOST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tag <= OWN_NONE;
        else
            r_tag <= w_tag_next;
    end

    assign host_gnt    = w_gnt;
    assign collide     = cv_rd & cv_wr;
    assign cv_rdata    = (r_tag == OWN_CV) ? mem_rdata : '0;
    assign host_rvalid = (r_tag == OWN_HOST);
    assign host_rdata  = (r_tag == OWN_HOST) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: rtl/conv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_arb
// Purpose  : Shares one SRAM between conv engine and host; sequences en_ctrl.
//            Optional macro ARB_STATS_EN adds stat_pause / stat_host_beats.
// Revision : 1.0  initial release
// ============================================================================
module conv_mem_arb
    import conv_mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int HOST_MAX_WAIT = DEF_HOST_MAX_WAIT,
    parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
    parameter int HOST_BURST    = DEF_HOST_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              conv_finish,
    output logic              conv_en,
    output logic              layer_done,
    input  logic              cv_rd,
    input  logic [ADDR_W-1:0] cv_rd_addr,
    output logic [DATA_W-1:0] cv_rdata,
    input  logic              cv_wr,
    input  logic [ADDR_W-1:0] cv_wr_addr,
    input  logic [DATA_W-1:0] cv_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_collide
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_pause,
    output logic [15:0]       stat_host_beats
`endif
);

    localparam int WAIT_W  = $clog2(HOST_MAX_WAIT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int BURST_W = $clog2(HOST_BURST + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(HOST_MAX_WAIT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(HOST_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST  = BURST_W'(HOST_BURST - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_next;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_layer_done;
    logic               r_err_collide;
    logic               w_conv_en;
    logic               w_host_allow;
    logic               w_host_gnt;
    logic               w_collide;

    arb_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .clk         (clk),
        .reset       (reset),
        .host_allow  (w_host_allow),
        .cv_rd       (cv_rd),
        .cv_rd_addr  (cv_rd_addr),
        .cv_wr       (cv_wr),
        .cv_wr_addr  (cv_wr_addr),
        .cv_wdata    (cv_wdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (w_host_gnt),
        .collide     (w_collide),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .cv_rdata    (cv_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

    // Grant window depends on state only, keeping it out of the grant/next-state loop.
    always_comb begin
        w_host_allow = 1'b0;
        case (r_state)
            ST_IDLE, ST_CONV, ST_DRAIN: w_host_allow = 1'b1;
            ST_HOST:                    w_host_allow = (r_burst_cnt < BURST_LIMIT);
            default:                    w_host_allow = 1'b0;
        endcase
    end

    // Starvation counter only lives in CONV; leaving CONV returns it to zero.
    always_comb begin
        w_wait_next = r_wait_cnt;
        if (r_state != ST_CONV || w_host_gnt)
            w_wait_next = '0;
        else if (host_req && r_wait_cnt != '1)
            w_wait_next = r_wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_conv_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run)
                    w_state_next = ST_CONV;
            end
            ST_CONV: begin
                w_conv_en = 1'b1;
                if (conv_finish)
                    w_state_next = ST_FINISH;
                else if (w_wait_next == WAIT_LIMIT)
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST)
                    w_state_next = ST_HOST;
            end
            ST_HOST: begin
                if (!host_req || (w_host_gnt && r_burst_cnt == BURST_LAST))
                    w_state_next = ST_CONV;
            end
            ST_FINISH: begin
                if (r_drain_cnt == DRAIN_LAST)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_drain_cnt   <= '0;
            r_burst_cnt   <= '0;
            r_layer_done  <= 1'b0;
            r_err_collide <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_next;

            if (w_state_next != r_state)
                r_drain_cnt <= '0;
            else if ((r_state == ST_DRAIN || r_state == ST_FINISH) && r_drain_cnt != '1)
                r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);

            if (r_state != ST_HOST)
                r_burst_cnt <= '0;
            else if (w_host_gnt && r_burst_cnt != '1)
                r_burst_cnt <= r_burst_cnt + BURST_W'(1);

            r_layer_done <= (r_state == ST_FINISH) && (w_state_next == ST_IDLE);

            if (w_collide)
                r_err_collide <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_pause;
    logic [15:0] r_stat_beats;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_pause <= '0;
            r_stat_beats <= '0;
        end else if (r_state == ST_IDLE && run) begin
            r_stat_pause <= '0;
            r_stat_beats <= '0;
        end else begin
            if (r_state == ST_CONV && w_state_next == ST_DRAIN)
                r_stat_pause <= sat_inc16(r_stat_pause);
            if (w_host_gnt)
                r_stat_beats <= sat_inc16(r_stat_beats);
        end
    end

    assign stat_pause      = r_stat_pause;
    assign stat_host_beats = r_stat_beats;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign conv_en     = w_conv_en;
    assign layer_done  = r_layer_done;
    assign err_collide = r_err_collide;
    assign host_gnt    = w_host_gnt;

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mem_arb
// Purpose  : Directed self-checking bench for conv_mem_arb with an SRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_mem_arb;

    logic        clk, reset, run, conv_finish;
    logic        conv_en, layer_done;
    logic        cv_rd, cv_wr;
    logic [15:0] cv_rd_addr, cv_wr_addr;
    logic [7:0]  cv_rdata, cv_wdata;
    logic        host_req, host_we, host_gnt, host_rvalid;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        err_collide;

    int n_tests = 0;
    int n_fail  = 0;

    conv_mem_arb dut (
        .clk(clk), .reset(reset), .run(run), .conv_finish(conv_finish),
        .conv_en(conv_en), .layer_done(layer_done),
        .cv_rd(cv_rd), .cv_rd_addr(cv_rd_addr), .cv_rdata(cv_rdata),
        .cv_wr(cv_wr), .cv_wr_addr(cv_wr_addr), .cv_wdata(cv_wdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_collide(err_collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM model with one-cycle read latency.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic run, fin, rd; logic [15:0] rd_a; logic wr; logic [15:0] wr_a; logic [7:0] wd;
        logic hreq, hwe; logic [15:0] ha; logic [7:0] hwd;
        logic en, gnt, ce, we; logic [15:0] ma; logic [7:0] mwd;
        logic rv; logic [7:0] hrd; logic cvv; logic [7:0] cvd; logic err;
    } vec_t;

    function automatic vec_t mk(
        input logic r, f, rd, input logic [15:0] rda, input logic wr, input logic [15:0] wra,
        input logic [7:0] wd, input logic hq, hw, input logic [15:0] ha, input logic [7:0] hwd,
        input logic en, g, ce, we, input logic [15:0] ma, input logic [7:0] mwd,
        input logic rv, input logic [7:0] hrd, input logic cvv, input logic [7:0] cvd, input logic err);
        vec_t v;
        v.run = r; v.fin = f; v.rd = rd; v.rd_a = rda; v.wr = wr; v.wr_a = wra; v.wd = wd;
        v.hreq = hq; v.hwe = hw; v.ha = ha; v.hwd = hwd;
        v.en = en; v.gnt = g; v.ce = ce; v.we = we; v.ma = ma; v.mwd = mwd;
        v.rv = rv; v.hrd = hrd; v.cvv = cvv; v.cvd = cvd; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 0; conv_finish = 0; cv_rd = 0; cv_rd_addr = '0; cv_wr = 0; cv_wr_addr = '0;
        cv_wdata = '0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic drive_host(input logic hq, input logic hw, input logic [15:0] a, input logic [7:0] d);
        host_req = hq; host_we = hw; host_addr = a; host_wdata = d;
    endtask

    vec_t vt [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        mem_rdata = 8'h00;
        idle_inputs();
        reset = 1'b1;

        //          run f rd rd_a    wr wr_a    wd     hq hw ha       hwd   | en g ce we ma       mwd    rv hrd    cvv cvd    err
        vt[0]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,16'h0000,8'h00, 0,8'h00, 0,8'h00, 0);
        vt[1]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 1,1,16'h0010,8'h5A, 0,1,1,1,16'h0010,8'h5A, 0,8'h00, 0,8'h00, 0);
        vt[2]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 1,0,16'h0010,8'h00, 0,1,1,0,16'h0010,8'h00, 0,8'h00, 0,8'h00, 0);
        vt[3]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,16'h0000,8'h00, 1,8'h5A, 0,8'h00, 0);
        vt[4]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 1,1,16'h0100,8'h33, 0,1,1,1,16'h0100,8'h33, 0,8'h00, 0,8'h00, 0);
        vt[5]  = mk(1,0,0,16'h0000,0,16'h0000,8'h00, 1,1,16'h0200,8'h77, 0,1,1,1,16'h0200,8'h77, 0,8'h00, 0,8'h00, 0);
        vt[6]  = mk(0,0,1,16'h0100,0,16'h0000,8'h00, 1,0,16'h0200,8'h00, 1,0,1,0,16'h0100,8'h00, 0,8'h00, 0,8'h00, 0);
        vt[7]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 1,0,16'h0200,8'h00, 1,1,1,0,16'h0200,8'h00, 0,8'h00, 1,8'h33, 0);
        vt[8]  = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,8'h00, 1,8'h77, 0,8'h00, 0);
        vt[9]  = mk(0,0,1,16'h0010,1,16'h0300,8'hC3, 0,0,16'h0000,8'h00, 1,0,1,1,16'h0300,8'hC3, 0,8'h00, 0,8'h00, 0);
        vt[10] = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,8'h00, 0,8'h00, 0,8'h00, 1);
        vt[11] = mk(0,0,1,16'h0300,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 1,0,1,0,16'h0300,8'h00, 0,8'h00, 0,8'h00, 1);
        vt[12] = mk(0,0,1,16'h0010,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 1,0,1,0,16'h0010,8'h00, 0,8'h00, 1,8'hC3, 1);
        vt[13] = mk(0,0,0,16'h0000,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,8'h00, 0,8'h00, 1,8'h5A, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset conv_en", conv_en, 0);
        chk("reset layer_done", layer_done, 0);
        chk("reset err_collide", err_collide, 0);
        chk("reset mem_ce", mem_ce, 0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 14; i++) begin
            run = vt[i].run; conv_finish = vt[i].fin;
            cv_rd = vt[i].rd; cv_rd_addr = vt[i].rd_a;
            cv_wr = vt[i].wr; cv_wr_addr = vt[i].wr_a; cv_wdata = vt[i].wd;
            drive_host(vt[i].hreq, vt[i].hwe, vt[i].ha, vt[i].hwd);
            #1;
            chk($sformatf("v%0d conv_en", i), conv_en, vt[i].en);
            chk($sformatf("v%0d host_gnt", i), host_gnt, vt[i].gnt);
            chk($sformatf("v%0d mem_ce", i), mem_ce, vt[i].ce);
            chk($sformatf("v%0d mem_we", i), mem_we, vt[i].we);
            if (vt[i].ce) chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].ma);
            if (vt[i].we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].mwd);
            chk($sformatf("v%0d host_rvalid", i), host_rvalid, vt[i].rv);
            if (vt[i].rv) chk($sformatf("v%0d host_rdata", i), host_rdata, vt[i].hrd);
            if (vt[i].cvv) chk($sformatf("v%0d cv_rdata", i), cv_rdata, vt[i].cvd);
            chk($sformatf("v%0d err_collide", i), err_collide, vt[i].err);
            cyc();
        end

        // Starvation: 8 waiting cycles in CONV, 4 drain cycles, 4 host beats, back to CONV.
        idle_inputs();
        for (int c = 1; c <= 8; c++) begin
            cv_rd = 1; cv_rd_addr = 16'(c);
            drive_host(1, 1, 16'h0400, 8'hA0);
            #1;
            chk($sformatf("starve c%0d conv_en", c), conv_en, 1);
            chk($sformatf("starve c%0d host_gnt", c), host_gnt, 0);
            cyc();
        end
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("drain c%0d conv_en", c), conv_en, 0);
            chk($sformatf("drain c%0d host_gnt", c), host_gnt, 0);
            chk($sformatf("drain c%0d mem_ce", c), mem_ce, 1);
            cyc();
        end
        cv_rd = 0;
        for (int b = 0; b < 4; b++) begin
            drive_host(1, 1, 16'h0400 + 16'(b), 8'hA0 + 8'(b));
            #1;
            chk($sformatf("burst b%0d conv_en", b), conv_en, 0);
            chk($sformatf("burst b%0d host_gnt", b), host_gnt, 1);
            chk($sformatf("burst b%0d mem_addr", b), mem_addr, 16'h0400 + 16'(b));
            cyc();
        end
        drive_host(0, 0, 16'h0000, 8'h00);
        cv_rd = 1; cv_rd_addr = 16'h0403;
        #1;
        chk("after burst conv_en", conv_en, 1);
        chk("after burst host_gnt", host_gnt, 0);
        cyc();
        cv_rd = 0;
        #1;
        chk("burst data cv_rdata", cv_rdata, 8'hA3);
        cyc();

        // Layer end: conv_finish coincides with the 8th waiting cycle and must win over DRAIN.
        for (int c = 1; c <= 8; c++) begin
            cv_rd = 1; cv_rd_addr = 16'h0000;
            drive_host(1, 0, 16'h0400, 8'h00);
            conv_finish = (c == 8);
            #1;
            chk($sformatf("fin c%0d conv_en", c), conv_en, 1);
            cyc();
        end
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            run = (k == 1);
            #1;
            chk($sformatf("finish k%0d conv_en", k), conv_en, 0);
            chk($sformatf("finish k%0d layer_done", k), layer_done, 0);
            cyc();
        end
        run = 0;
        #1;
        chk("layer_done pulse", layer_done, 1);
        chk("layer_done conv_en", conv_en, 0);
        cyc();
        drive_host(1, 0, 16'h0010, 8'h00);
        #1;
        chk("post layer_done", layer_done, 0);
        chk("idle host_gnt", host_gnt, 1);
        chk("idle conv_en", conv_en, 0);
        cyc();
        drive_host(0, 0, 16'h0000, 8'h00);
        run = 1;
        #1;
        chk("idle host_rdata", host_rdata, 8'h5A);
        cyc();

        // Async reset while in DRAIN.
        run = 0;
        for (int c = 1; c <= 8; c++) begin
            cv_rd = 1; cv_rd_addr = 16'h0001;
            drive_host(1, 0, 16'h0010, 8'h00);
            cyc();
        end
        #1;
        chk("pre-reset drain conv_en", conv_en, 0);
        chk("pre-reset err_collide", err_collide, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async reset conv_en", conv_en, 0);
        chk("async reset err_collide", err_collide, 0);
        chk("async reset mem_ce", mem_ce, 0);
        chk("async reset mem_addr", mem_addr, 0);
        chk("async reset host_gnt", host_gnt, 0);
        chk("async reset cv_rdata", cv_rdata, 0);
        chk("async reset layer_done", layer_done, 0);
        cyc();
        idle_inputs();
        reset = 1'b0;
        cyc();
        run = 1;
        cyc();
        run = 0;
        cv_rd = 1; cv_rd_addr = 16'h0403;
        drive_host(1, 0, 16'h0010, 8'h00);
        #1;
        chk("restart conv_en", conv_en, 1);
        chk("restart host_gnt", host_gnt, 0);
        chk("restart mem_addr", mem_addr, 16'h0403);
        chk("restart err_collide", err_collide, 0);
        cyc();
        cv_rd = 0;
        #1;
        chk("restart host_gnt free slot", host_gnt, 1);
        chk("restart cv_rdata", cv_rdata, 8'hA3);
        cyc();
        idle_inputs();
        #1;
        chk("restart host_rvalid", host_rvalid, 1);
        chk("restart host_rdata", host_rdata, 8'h5A);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
